// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between the ALU (A) and load (B) writeback paths.
// Loads win by default; a starvation counter forces an ALU grant, and same-register collisions keep load-then-ALU order.
module regfile_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  parameter int ZERO_REG   = 31,
  parameter int MAX_WAIT   = 4,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  force_a
);

  localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = ADDR_W'(ZERO_REG);

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_FORCE_A = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wait_q, wait_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    a_grant_s, b_grant_s;

  // Grant selection; a matching address always goes to the older load first.
  always_comb begin
    a_grant_s = 1'b0;
    b_grant_s = 1'b0;
    if (!reset_n || stall) begin
      a_grant_s = 1'b0;
      b_grant_s = 1'b0;
    end else if (a_valid && b_valid) begin
      if ((a_addr == b_addr) || (state_q == ST_NORMAL)) begin
        b_grant_s = 1'b1;
      end else begin
        a_grant_s = 1'b1;
      end
    end else begin
      a_grant_s = a_valid;
      b_grant_s = b_valid;
    end
  end

  // Next-state for the output register, starvation counter and force state.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wait_d    = wait_q;
    state_d   = state_q;

    if (a_grant_s) begin
      wr_en_d   = (a_addr != ZERO_ADDR);
      wr_addr_d = a_addr;
      wr_data_d = a_data;
    end else if (b_grant_s) begin
      wr_en_d   = (b_addr != ZERO_ADDR);
      wr_addr_d = b_addr;
      wr_data_d = b_data;
    end else begin
      wr_en_d   = 1'b0;
    end

    if (stall) begin
      wait_d = wait_q;
    end else if (!a_valid || a_grant_s) begin
      wait_d = 4'd0;
    end else if (wait_q < MAX_WAIT_C) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end

    case (state_q)
      ST_NORMAL: begin
        if (wait_d == MAX_WAIT_C) begin
          state_d = ST_FORCE_A;
        end else begin
          state_d = ST_NORMAL;
        end
      end
      ST_FORCE_A: begin
        if (a_grant_s) begin
          state_d = ST_NORMAL;
        end else begin
          state_d = ST_FORCE_A;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // State and output registers; reset drops any pending write immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_NORMAL;
      wait_q    <= 4'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign a_ready = a_grant_s;
  assign b_ready = b_grant_s;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign force_a = (state_q == ST_FORCE_A);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations, then
// randomized requesters checked every cycle against a streak-count model of the arbitration rules.
module tb_regfile_write_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int ZR = 31;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          stall, a_valid, b_valid;
  logic          a_ready, b_ready, wr_en, force_a;
  logic [AW-1:0] a_addr, b_addr, wr_addr;
  logic [DW-1:0] a_data, b_data, wr_data;

  int checks = 0;
  int errors = 0;

  // Model: A is forced once it has been blocked MW unstalled cycles in a row.
  int            streak;
  logic          m_wr_en;
  logic [AW-1:0] m_wr_addr;
  logic [DW-1:0] m_wr_data;

  regfile_write_arbiter dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .force_a(force_a)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // {a_grant, b_grant} straight from the arbitration rules.
  function automatic logic [1:0] model_grant();
    if (!reset_n || stall) return 2'b00;
    if (a_valid && b_valid) return ((a_addr == b_addr) || (streak < MW)) ? 2'b01 : 2'b10;
    return {a_valid, b_valid};
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] r;
    case ($urandom_range(0, 3))
      0:       r = 5'd3;
      1:       r = 5'd9;
      2:       r = 5'd31;
      default: r = AW'($urandom_range(0, 31));
    endcase
    return r;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model on the clock edge.
  initial begin
    logic [1:0] g;
    streak = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        streak = 0; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
      end
      g = model_grant();
      chk("a_ready", a_ready, g[1]);
      chk("b_ready", b_ready, g[0]);
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_addr", wr_addr, m_wr_addr);
      chk("wr_data", wr_data, m_wr_data);
      chk("force_a", force_a, streak >= MW);
      @(posedge clk);
      if (reset_n) begin
        g = model_grant();
        if (g[1]) begin
          m_wr_en = (a_addr != ZR); m_wr_addr = a_addr; m_wr_data = a_data;
        end else if (g[0]) begin
          m_wr_en = (b_addr != ZR); m_wr_addr = b_addr; m_wr_data = b_data;
        end else begin
          m_wr_en = 1'b0;
        end
        if (!stall) streak = (!a_valid || g[1]) ? 0 : streak + 1;
      end
    end
  end

  // Stimulus: directed scenarios with hand-computed values, then random traffic.
  initial begin
    logic a_fire, b_fire;
    stall = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_addr = 5'd1; b_addr = 5'd2; a_data = '0; b_data = '0;
    #1 reset_n = 1'b0;
    next_cycle(); next_cycle();
    @(negedge clk);
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_a_ready", a_ready, 1'b0);
    chk("rst_b_ready", b_ready, 1'b0);
    chk("rst_force_a", force_a, 1'b0);
    next_cycle();
    reset_n = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    next_cycle();

    // A alone
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h1234;
    @(negedge clk);
    chk("alone_a_ready", a_ready, 1'b1);
    next_cycle(); a_valid = 1'b0;
    @(negedge clk);
    chk("alone_wr_en", wr_en, 1'b1);
    chk("alone_wr_addr", wr_addr, 5'd5);
    chk("alone_wr_data", wr_data, 64'h1234);
    next_cycle();
    @(negedge clk);
    chk("alone_wr_en_off", wr_en, 1'b0);
    next_cycle();

    // Contention: B wins four cycles, then A is forced
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'hA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'h100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_b_ready", b_ready, k != 4);
      chk("cont_a_ready", a_ready, k == 4);
      chk("cont_force_a", force_a, k == 4);
      if (k == 5) begin
        chk("cont_wr_addr", wr_addr, 5'd3);
        chk("cont_wr_data", wr_data, 64'hA);
      end
      next_cycle();
      if (k == 4) a_valid = 1'b0;
      if (k != 4) b_data = b_data + 64'd1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    next_cycle();

    // Same address while forced: B first, then A
    a_valid = 1'b1; a_addr = 5'd9; a_data = 64'hAAAA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("same_pre_b_ready", b_ready, 1'b1);
      next_cycle();
      b_data = b_data + 64'd1;
      if (k == 3) begin b_addr = 5'd9; b_data = 64'hBBBB; end
    end
    @(negedge clk);
    chk("same_force_a", force_a, 1'b1);
    chk("same_b_ready", b_ready, 1'b1);
    chk("same_a_ready", a_ready, 1'b0);
    next_cycle(); b_valid = 1'b0;
    @(negedge clk);
    chk("same_a_ready2", a_ready, 1'b1);
    chk("same_force_a2", force_a, 1'b1);
    chk("same_wr_data_b", wr_data, 64'hBBBB);
    next_cycle(); a_valid = 1'b0;
    @(negedge clk);
    chk("same_force_clr", force_a, 1'b0);
    chk("same_wr_addr", wr_addr, 5'd9);
    chk("same_wr_data_a", wr_data, 64'hAAAA);
    next_cycle();

    // Zero register write is accepted but not enabled
    b_valid = 1'b1; b_addr = 5'd31; b_data = 64'hFFFF;
    @(negedge clk);
    chk("zero_b_ready", b_ready, 1'b1);
    next_cycle(); b_valid = 1'b0;
    @(negedge clk);
    chk("zero_wr_en", wr_en, 1'b0);
    chk("zero_wr_addr", wr_addr, 5'd31);
    chk("zero_wr_data", wr_data, 64'hFFFF);
    next_cycle();

    // Stall freezes the starvation count, then reset mid-stream
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'hC;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'h300;
    for (int k = 0; k < 2; k++) begin
      next_cycle(); b_data = b_data + 64'd1;
    end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_a_ready", a_ready, 1'b0);
      chk("stall_b_ready", b_ready, 1'b0);
      if (k > 0) chk("stall_wr_en", wr_en, 1'b0);
      next_cycle();
    end
    stall = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("unstall_b_ready", b_ready, 1'b1);
      chk("unstall_force_a", force_a, 1'b0);
      next_cycle(); b_data = b_data + 64'd1;
    end
    @(negedge clk);
    chk("unstall_a_ready", a_ready, 1'b1);
    chk("unstall_force_a2", force_a, 1'b1);
    next_cycle();
    a_data = 64'hD; reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_wr_en", wr_en, 1'b0);
    chk("mid_rst_wr_addr", wr_addr, 5'd0);
    chk("mid_rst_wr_data", wr_data, 64'd0);
    chk("mid_rst_force_a", force_a, 1'b0);
    next_cycle(); reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_b_ready", b_ready, 1'b1);
    chk("post_rst_a_ready", a_ready, 1'b0);

    // Random traffic; requesters hold their request until it transfers
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      next_cycle();
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      if (!a_valid || a_fire) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = pick_addr();
        a_data  = {$urandom, $urandom};
      end
      if (!b_valid || b_fire) begin
        b_valid = ($urandom_range(0, 3) != 0);
        b_addr  = pick_addr();
        b_data  = {$urandom, $urandom};
      end
      stall = ($urandom_range(0, 7) == 0);
    end
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters.
  - Requester A: the ALU/execute result.
  - Requester B: the load/memory result.
- Each cycle it grants at most one requester and registers the winner's destination index and data.
- The registered index and enable drive the recursive write-enable decoder. The registered data drives the register file write data bus.
- Default priority goes to loads. A starvation counter guarantees ALU progress. Same-register collisions are ordered oldest-first.

Parameters:
- DATA_WIDTH, 64: width of write data.
- NUM_REGS, 32: number of architectural registers. Must be a power of two ≥2. ADDR_W = $clog2(NUM_REGS).
- ZERO_REG, 31: index of the hardwired-zero register. Writes to it are accepted and discarded.
- MAX_WAIT, 4: number of consecutive blocked cycles for A before A is forced to win. Range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  register file write port unavailable this cycle.
- a_valid  in  1  A has a result to write.
- a_ready  out  1  A transfer accepted this cycle (combinational).
- a_addr  in  ADDR_W  A destination register.
- a_data  in  DATA_WIDTH  A result.
- b_valid  in  1  B has a result to write.
- b_ready  out  1  B transfer accepted this cycle (combinational).
- b_addr  in  ADDR_W  B destination register.
- b_data  in  DATA_WIDTH  B result.
- wr_en  out  1  decoder enable, registered.
- wr_addr  out  ADDR_W  decoder select, registered.
- wr_data  out  DATA_WIDTH  write data, registered.
- force_a  out  1  high while in state FORCE_A (debug/perf).

Behaviour:
- Reset (reset_n low, asynchronous):
  - wr_en=0, wr_addr=0, wr_data=0.
  - state=NORMAL, force_a=0, wait_a=0.
  - a_ready=b_ready=0 while reset_n is low.
- Transfer: a requester transfers on a rising edge when valid && ready. A requester may not drop valid or change addr/data until it transfers. The arbiter does not check this; the bench asserts it.
- Grant logic (combinational, all zero when stall=1):
  - Only one valid: that requester is granted.
  - Both valid and a_addr==b_addr: B is granted regardless of state, because the load is older. A goes on a later cycle, so A's value is the final one.
  - Both valid, addresses differ, state NORMAL: B is granted.
  - Both valid, addresses differ, state FORCE_A: A is granted.
  - At most one of a_ready/b_ready is high in any cycle.
- Output register, 1-cycle latency:
  - On a transfer, next cycle wr_addr/wr_data take the granted addr/data.
  - wr_en=1 unless the granted addr==ZERO_REG, in which case wr_en=0 (wr_addr/wr_data still update).
  - No transfer (idle or stall): wr_en=0 next cycle; wr_addr/wr_data hold.
- wait_a counter, 4 bits:
  - +1 per cycle with a_valid && !a_ready && !stall, saturating at MAX_WAIT.
  - Cleared on an A transfer, or on any cycle with a_valid=0.
  - Frozen while stall=1.
- State machine:
  - NORMAL → FORCE_A when the updated wait_a reaches MAX_WAIT.
  - FORCE_A → NORMAL on the edge where A transfers.
  - FORCE_A holds through stall and through same-address B grants.
  - force_a = (state==FORCE_A).
- Simultaneous events:
  - A stall arriving while in FORCE_A does not change state.
  - reset_n asserted mid-transfer discards the pending output immediately; no write occurs.
  - On reset release, the first grant is evaluated on the first edge with reset_n high.

Test Plan:
- Reset: hold reset_n=0 with a_valid=b_valid=1 → wr_en=0, wr_addr=0, wr_data=0, a_ready=b_ready=0, force_a=0.
- A alone, a_addr=5, a_data=0x1234 → a_ready=1 the same cycle; next cycle wr_en=1, wr_addr=5, wr_data=0x1234; following cycle wr_en=0.
- Contention (MAX_WAIT=4): A valid addr 3, B valid every cycle with addr 7 and fresh data → B granted cycles 0-3; force_a=1 from cycle 4; A granted cycle 4; force_a=0 cycle 5; B resumes.
- Same address: a_addr=b_addr=9 with state forced to FORCE_A → B written first, A one cycle later; final write is A's data; force_a clears after A transfers.
- Zero register: B addr 31, data 0xFFFF → b_ready=1; next cycle wr_en=0, wr_addr=31.
- Stall and reset: stall=1 for 3 cycles during contention → readies 0, wr_en=0, wait_a frozen. Then reset_n pulsed low mid-stream → all outputs 0 asynchronously; after release, normal B-priority arbitration restarts.
